// File: rtl/eth_tx_queue_arbiter.sv
// eth_tx_queue_arbiter: packet-granular scheduler of NUM_Q cmd/data FIFO pairs onto one GMII TX cmd/data interface
// Ports: i_clk, i_reset (async, active-high); per-queue i_q_cmd_empty/o_q_cmd_rd/i_q_cmd_data (72b each),
//   i_q_data_empty/o_q_data_rd/i_q_data_data (9b each); downstream i_cmd_fifo_rd/o_cmd_fifo_data_out/o_cmd_fifo_empty,
//   i_data_fifo_rd/o_data_fifo_data_out/o_data_fifo_empty; o_grant_q current grant; o_drop_pulse one pulse per drop.
// Build option: ETH_TX_ARB_STRICT_PRIO_EN selects strict priority (queue 0 highest) instead of round-robin.
module eth_tx_queue_arbiter #(
  parameter int          NUM_Q   = 4,
  parameter logic [13:0] LEN_MIN = 14'd60
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_Q-1:0]    i_q_cmd_empty,
  output logic [NUM_Q-1:0]    o_q_cmd_rd,
  input  logic [72*NUM_Q-1:0] i_q_cmd_data,
  input  logic [NUM_Q-1:0]    i_q_data_empty,
  output logic [NUM_Q-1:0]    o_q_data_rd,
  input  logic [9*NUM_Q-1:0]  i_q_data_data,
  input  logic                i_cmd_fifo_rd,
  output logic [71:0]         o_cmd_fifo_data_out,
  output logic                o_cmd_fifo_empty,
  input  logic                i_data_fifo_rd,
  output logic [8:0]          o_data_fifo_data_out,
  output logic                o_data_fifo_empty,
  output logic [2:0]          o_grant_q,
  output logic                o_drop_pulse
);
  typedef enum logic [2:0] {ARB_IDLE, ARB_OFFER, ARB_LATCH1, ARB_LATCH2, ARB_BUSY, ARB_DRAIN, ARB_RELEASE} state_t;
  state_t      r_st, w_nst;
  logic [2:0]  r_grant, r_rr, w_pick, w_rr_nxt;
  logic [13:0] r_len, r_cnt, w_len;
  logic        w_ce, w_de, w_any, w_inv, w_done, w_cmd_rd, w_fwd, w_drain, w_data_rd;
  logic [71:0] w_cd;
  logic [8:0]  w_dd;
  always_comb begin
    w_ce = 1'b1;
    w_de = 1'b1;
    w_cd = '0;
    w_dd = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (r_grant == 3'(i)) begin
        w_ce = i_q_cmd_empty[i];
        w_de = i_q_data_empty[i];
        w_cd = i_q_cmd_data[72*i +: 72];
        w_dd = i_q_data_data[9*i +: 9];
      end
    end
  end
  // Lowest non-empty queue overall, overridden by the lowest non-empty at or above r_rr: a wrapping search.
  // With r_rr pinned at 0 this degenerates to strict priority.
  always_comb begin
    w_pick = r_grant;
    for (int i = NUM_Q-1; i >= 0; i--) if (!i_q_cmd_empty[i]) w_pick = 3'(i);
    for (int i = NUM_Q-1; i >= 0; i--) if (!i_q_cmd_empty[i] && 3'(i) >= r_rr) w_pick = 3'(i);
  end
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
  assign w_rr_nxt = 3'd0;
`else
  assign w_rr_nxt = (r_grant == 3'(NUM_Q-1)) ? 3'd0 : r_grant + 3'd1;
`endif
  assign w_any     = ~&i_q_cmd_empty;
  assign w_len     = w_cd[13:0];
  assign w_inv     = w_cd[53] | w_cd[52] | (w_len < LEN_MIN);
  assign w_done    = r_cnt == r_len;
  assign w_cmd_rd  = (r_st == ARB_OFFER) & i_cmd_fifo_rd & ~w_ce;
  assign w_fwd     = (r_st == ARB_BUSY) & i_data_fifo_rd & ~w_de & ~w_done;
  assign w_drain   = (r_st == ARB_DRAIN) & ~w_de & ~w_done;
  assign w_data_rd = w_fwd | w_drain;
  always_comb begin
    o_q_cmd_rd  = '0;
    o_q_data_rd = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      o_q_cmd_rd[i]  = w_cmd_rd & (r_grant == 3'(i));
      o_q_data_rd[i] = w_data_rd & (r_grant == 3'(i));
    end
  end
  assign o_cmd_fifo_data_out  = w_cd;
  assign o_cmd_fifo_empty     = (r_st == ARB_OFFER) ? w_ce : 1'b1;
  assign o_data_fifo_data_out = w_dd;
  assign o_data_fifo_empty    = (r_st == ARB_BUSY && !w_done) ? w_de : 1'b1;
  assign o_grant_q            = r_grant;
  assign o_drop_pulse         = (r_st == ARB_LATCH2) & w_inv;
  always_comb begin
    w_nst = r_st;
    case (r_st)
      ARB_IDLE:            w_nst = w_any ? ARB_OFFER : ARB_IDLE;
      ARB_OFFER:           w_nst = w_cmd_rd ? ARB_LATCH1 : ARB_OFFER;
      ARB_LATCH1:          w_nst = ARB_LATCH2;
      ARB_LATCH2:          w_nst = !w_inv ? ARB_BUSY : (w_len == 14'd0) ? ARB_RELEASE : ARB_DRAIN;
      ARB_BUSY, ARB_DRAIN: w_nst = w_done ? ARB_RELEASE : r_st;
      ARB_RELEASE:         w_nst = ARB_IDLE;
      default:             w_nst = ARB_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_st    <= ARB_IDLE;
      r_grant <= '0;
      r_rr    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_st <= w_nst;
      if (r_st == ARB_IDLE) r_grant <= w_pick;
      if (r_st == ARB_LATCH2) r_len <= w_len;
      if (r_st == ARB_RELEASE) r_rr <= w_rr_nxt;
      r_cnt <= (r_st == ARB_RELEASE) ? 14'd0 : r_cnt + 14'(w_data_rd);
    end
  end
endmodule

// File: tb/tb_eth_tx_queue_arbiter.sv
// tb_eth_tx_queue_arbiter: scoreboard bench with upstream FIFO models and a packet-level reference scheduler
`timescale 1ns/1ps
module tb_eth_tx_queue_arbiter;
  localparam int NQ = 4;
  typedef struct {int q; logic [71:0] w; int seq;} ent_t;
  logic            clk = 1'b0, rst = 1'b1;
  logic [NQ-1:0]   cemp = '1, demp = '1, q_cmd_rd, q_data_rd, oh;
  logic [71:0]     cdout [NQ];
  logic [8:0]      ddout [NQ];
  logic [72*NQ-1:0] cbus;
  logic [9*NQ-1:0] dbus;
  logic            cmd_rd = 1'b0, data_rd = 1'b0, cmd_empty, data_empty, drop;
  logic [71:0]     cmd_out;
  logic [8:0]      data_out;
  logic [2:0]      grant;
  logic [71:0]     cq [NQ][$];
  logic [8:0]      dq [NQ][$];
  logic [71:0]     stc [NQ][$];
  logic [8:0]      stb [NQ][$];
  ent_t            exp_cmd[$], exp_byte[$], e;
  int              exp_drop[$];
  int              checks = 0, failures = 0, seq = 0, rr_m = 0, exp_drain = 0, drain_seen = 0, bytes_seen = 0;
  bit              force_rd = 1'b0, pend_c = 1'b0, pend_d = 1'b0;
  always #4 clk = ~clk;
  always_comb for (int i = 0; i < NQ; i++) begin
    cbus[72*i +: 72] = cdout[i];
    dbus[9*i +: 9]   = ddout[i];
  end
  eth_tx_queue_arbiter #(.NUM_Q(NQ), .LEN_MIN(14'd60)) dut (
    .i_clk(clk), .i_reset(rst), .i_q_cmd_empty(cemp), .o_q_cmd_rd(q_cmd_rd), .i_q_cmd_data(cbus),
    .i_q_data_empty(demp), .o_q_data_rd(q_data_rd), .i_q_data_data(dbus), .i_cmd_fifo_rd(cmd_rd),
    .o_cmd_fifo_data_out(cmd_out), .o_cmd_fifo_empty(cmd_empty), .i_data_fifo_rd(data_rd),
    .o_data_fifo_data_out(data_out), .o_data_fifo_empty(data_empty), .o_grant_q(grant), .o_drop_pulse(drop));
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  // Upstream FIFOs: 1-cycle read latency, registered empty flags.
  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (rst) begin
        cdout[i] <= '0;
        ddout[i] <= '0;
      end
      if (q_cmd_rd[i]) begin
        if (cq[i].size() == 0) chk("cmd_underflow", 72'(i), 72'(99));
        else cdout[i] <= cq[i].pop_front();
      end
      if (q_data_rd[i]) begin
        if (dq[i].size() == 0) chk("data_underflow", 72'(i), 72'(99));
        else ddout[i] <= dq[i].pop_front();
      end
      cemp[i] <= cq[i].size() == 0;
      demp[i] <= dq[i].size() == 0;
    end
  end
  // Downstream driver and monitor.
  always @(negedge clk) begin
    if (rst) begin
      pend_c  = 1'b0;
      pend_d  = 1'b0;
      cmd_rd  = force_rd;
      data_rd = force_rd;
    end else begin
      if (pend_c) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 72'(1), 72'(0));
        else begin
          e = exp_cmd.pop_front();
          chk("cmd_word", cmd_out, e.w);
          chk("cmd_grant", 72'(grant), 72'(e.q));
          chk("grant_overlap", 72'(exp_byte.size() > 0 && exp_byte[0].seq < e.seq), 72'(0));
        end
      end
      if (pend_d) begin
        if (exp_byte.size() == 0) chk("byte_unexpected", 72'(1), 72'(0));
        else begin
          e = exp_byte.pop_front();
          chk("byte", 72'(data_out), e.w);
          chk("byte_grant", 72'(grant), 72'(e.q));
          bytes_seen++;
        end
      end
      if (drop) begin
        if (exp_drop.size() == 0) chk("drop_unexpected", 72'(1), 72'(0));
        else chk("drop_grant", 72'(grant), 72'(exp_drop.pop_front()));
      end
      cmd_rd  = !cmd_empty ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
      data_rd = !data_empty ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
      pend_c  = cmd_rd & !cmd_empty;
      pend_d  = data_rd & !data_empty;
      #1;
      oh = NQ'(1) << grant;
      chk("cmd_strobe", 72'(q_cmd_rd), 72'(pend_c ? oh : '0));
      chk("data_strobe_other", 72'(q_data_rd & ~oh), 72'(0));
      if (pend_d) chk("data_strobe_fwd", 72'(q_data_rd), 72'(oh));
      else if (q_data_rd != '0) begin
        drain_seen++;
        chk("drain_cmd_empty", 72'(cmd_empty), 72'(1));
        chk("drain_data_empty", 72'(data_empty), 72'(1));
      end
    end
  end
  task automatic stage(input int q, input int len, input logic [1:0] err);
    logic [71:0] w;
    logic [8:0]  b;
    w[31:0]  = $urandom();
    w[63:32] = $urandom();
    w[71:64] = 8'($urandom());
    w[13:0]  = 14'(len);
    w[53:52] = err;
    cq[q].push_back(w);
    stc[q].push_back(w);
    for (int k = 0; k < len; k++) begin
      b = 9'($urandom());
      dq[q].push_back(b);
      stb[q].push_back(b);
    end
  endtask
  // Reference: the next staged packet of queue q is granted; valid ones deliver bytes, others are dropped.
  task automatic take(input int q);
    logic [71:0] w;
    logic [8:0]  b;
    int          len;
    bit          ok;
    w   = stc[q].pop_front();
    len = int'(w[13:0]);
    ok  = (w[53:52] == 2'b00) && (len >= 60);
    seq++;
    exp_cmd.push_back(ent_t'{q, w, seq});
    for (int k = 0; k < len; k++) begin
      b = stb[q].pop_front();
      if (ok) exp_byte.push_back(ent_t'{q, 72'(b), seq});
    end
    if (!ok) begin
      exp_drop.push_back(q);
      exp_drain += len;
    end
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    rr_m = 0;
`else
    rr_m = (q + 1) % NQ;
`endif
  endtask
  task automatic model_all();
    int sel;
    while (1) begin
      sel = -1;
      for (int k = NQ-1; k >= 0; k--) if (stc[(rr_m + k) % NQ].size() > 0) sel = (rr_m + k) % NQ;
      if (sel < 0) break;
      take(sel);
    end
  endtask
  task automatic wait_done(input string nm, input int budget);
    int n, quiet;
    bit idle;
    n = 0;
    quiet = 0;
    while (quiet < 6 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      idle = exp_cmd.size() == 0 && exp_byte.size() == 0 && exp_drop.size() == 0;
      for (int i = 0; i < NQ; i++) idle = idle && cq[i].size() == 0 && dq[i].size() == 0;
      quiet = idle ? quiet + 1 : 0;
    end
    chk({nm, "_complete"}, 72'(quiet >= 6), 72'(1));
    chk({nm, "_drain_count"}, 72'(drain_seen), 72'(exp_drain));
    chk({nm, "_idle_cmd_empty"}, 72'(cmd_empty), 72'(1));
    chk({nm, "_idle_data_empty"}, 72'(data_empty), 72'(1));
  endtask
  task automatic reset_checks(input string nm);
    chk({nm, "_grant"}, 72'(grant), 72'(0));
    chk({nm, "_q_cmd_rd"}, 72'(q_cmd_rd), 72'(0));
    chk({nm, "_q_data_rd"}, 72'(q_data_rd), 72'(0));
    chk({nm, "_cmd_empty"}, 72'(cmd_empty), 72'(1));
    chk({nm, "_data_empty"}, 72'(data_empty), 72'(1));
    chk({nm, "_drop"}, 72'(drop), 72'(0));
  endtask
  initial begin
    int b0, n, len;
    logic [1:0] err;
    force_rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;
    force_rd = 1'b0;
    @(negedge clk);
    stage(0, 64, 2'b00);
    model_all();
    wait_done("t1_single", 4000);
    @(negedge clk);
    for (int q = 0; q < NQ; q++) repeat (2) stage(q, 60 + $urandom_range(20), 2'b00);
    model_all();
    wait_done("t2_all_queues", 4000);
    @(negedge clk);
    stage(1, 100, 2'b01);
    model_all();
    wait_done("t3_err_drop", 4000);
    @(negedge clk);
    stage(2, 59, 2'b00);
    stage(2, 60, 2'b00);
    model_all();
    wait_done("t4_runt", 4000);
    @(negedge clk);
    stage(3, 64, 2'b00);
    stage(3, 64, 2'b00);
    take(3);
    b0 = bytes_seen;
    n = 0;
    while (bytes_seen < b0 + 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_q3_busy", 72'(bytes_seen >= b0 + 5), 72'(1));
    stage(0, 64, 2'b00);
    take(0);
    take(3);
    wait_done("t5_late_q0", 4000);
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      for (int q = 0; q < NQ; q++) begin
        repeat ($urandom_range(2)) begin
          n = $urandom_range(9);
          len = (n == 0) ? 0 : (n < 3) ? 1 + $urandom_range(58) : 60 + $urandom_range(30);
          err = ($urandom_range(5) == 0) ? 2'(1 + $urandom_range(2)) : 2'b00;
          stage(q, len, err);
        end
      end
      model_all();
      wait_done("rand", 4000);
    end
    @(negedge clk);
    stage(0, 64, 2'b00);
    model_all();
    b0 = bytes_seen;
    n = 0;
    while (bytes_seen < b0 + 30 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_byte30", 72'(bytes_seen >= b0 + 30), 72'(1));
    @(posedge clk);
    #2;
    force_rd = 1'b1;
    rst = 1'b1;
    for (int q = 0; q < NQ; q++) begin
      cq[q].delete();
      dq[q].delete();
      stc[q].delete();
      stb[q].delete();
    end
    exp_cmd.delete();
    exp_byte.delete();
    exp_drop.delete();
    exp_drain = drain_seen;
    rr_m = 0;
    @(posedge clk);
    #1;
    reset_checks("t6_mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    force_rd = 1'b0;
    @(negedge clk);
    for (int q = 0; q < NQ; q++) stage(q, 60 + $urandom_range(10), (q == 2) ? 2'b10 : 2'b00);
    model_all();
    wait_done("t6_recover", 4000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
